// File: rtl/adder_resp_checker.sv
// Response checker for the adder family: scores {carry,sum} against a+b, counts
// checks/errors, latches the first failing vector and tracks {a,b} coverage.
// Optional build macro ADDER_RESP_CHECKER_STOP_ON_ERR_EN aborts the run into FAIL on the first mismatch.
module adder_resp_checker #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             cov_full,
  output logic             first_err_vld,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b
);

  localparam int unsigned IDX_W = 2 * WIDTH;
  localparam int unsigned COV_N = 1 << IDX_W;
  localparam int unsigned RES_W = WIDTH + 1;

`ifdef ADDER_RESP_CHECKER_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_FAIL = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   chk_q, chk_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [COV_N-1:0]   cov_q, cov_d;
  logic               cov_full_q, cov_full_d;
  logic               fe_vld_q, fe_vld_d;
  logic [WIDTH-1:0]   fe_a_q, fe_a_d;
  logic [WIDTH-1:0]   fe_b_q, fe_b_d;

  logic               accept_c;
  logic               mismatch_c;
  logic [RES_W-1:0]   exp_c;
  logic [IDX_W-1:0]   idx_c;
  logic [COV_N-1:0]   cov_upd_c;
  logic               cov_upd_full_c;
  logic [CNT_W-1:0]   chk_upd_c;
  logic [CNT_W-1:0]   err_upd_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A beat coinciding with start is dropped: the run it belonged to is being discarded.
  assign accept_c   = in_valid & ready_q & ~start;
  assign exp_c      = RES_W'(a) + RES_W'(b);
  assign mismatch_c = (exp_c != {carry, sum});
  assign idx_c      = {a, b};
  assign chk_upd_c  = sat_inc(chk_q);
  assign err_upd_c  = mismatch_c ? sat_inc(err_q) : err_q;

  // Coverage bitmap as it would look after recording the current beat.
  always_comb begin
    cov_upd_c        = cov_q;
    cov_upd_c[idx_c] = 1'b1;
    cov_upd_full_c   = &cov_upd_c;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    chk_d      = chk_q;
    err_d      = err_q;
    cov_d      = cov_q;
    cov_full_d = cov_full_q;
    fe_vld_d   = fe_vld_q;
    fe_a_d     = fe_a_q;
    fe_b_d     = fe_b_q;

    if (start) begin
      state_d    = S_RUN;
      ready_d    = 1'b1;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      chk_d      = '0;
      err_d      = '0;
      cov_d      = '0;
      cov_full_d = 1'b0;
      fe_vld_d   = 1'b0;
      fe_a_d     = '0;
      fe_b_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_d = 1'b0;
          busy_d  = 1'b0;
        end
        S_RUN: begin
          if (accept_c) begin
            chk_d      = chk_upd_c;
            err_d      = err_upd_c;
            cov_d      = cov_upd_c;
            cov_full_d = cov_upd_full_c;
            if (mismatch_c && !fe_vld_q) begin
              fe_vld_d = 1'b1;
              fe_a_d   = a;
              fe_b_d   = b;
            end
            if (STOP_ON_ERR && mismatch_c) begin
              state_d = S_FAIL;
              ready_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = 1'b0;
            end else if (cov_upd_full_c) begin
              state_d = S_DONE;
              ready_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_upd_c == '0);
            end
          end
        end
        S_DONE, S_FAIL: begin
          ready_d = 1'b0;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          ready_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      chk_q      <= '0;
      err_q      <= '0;
      cov_q      <= '0;
      cov_full_q <= 1'b0;
      fe_vld_q   <= 1'b0;
      fe_a_q     <= '0;
      fe_b_q     <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      chk_q      <= chk_d;
      err_q      <= err_d;
      cov_q      <= cov_d;
      cov_full_q <= cov_full_d;
      fe_vld_q   <= fe_vld_d;
      fe_a_q     <= fe_a_d;
      fe_b_q     <= fe_b_d;
    end
  end

  assign in_ready      = ready_q & ~start;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign chk_cnt       = chk_q;
  assign err_cnt       = err_q;
  assign cov_full      = cov_full_q;
  assign first_err_vld = fe_vld_q;
  assign first_err_a   = fe_a_q;
  assign first_err_b   = fe_b_q;

endmodule
